// File: rtl/tlul_pkg.sv
// TL-UL shared definitions for the N:1 crossbar: A/D opcodes used by the
// internal error responder and the A-channel FSM state encoding.
package tlul_pkg;

    localparam logic [2:0] PUT_FULL        = 3'd0;
    localparam logic [2:0] PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] GET             = 3'd4;
    localparam logic [2:0] ACCESS_ACK      = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

    typedef enum logic {ARB, FWD} a_state_e;

endpackage

// File: rtl/tlul_rr_arbiter.sv
// Combinational round-robin picker.
//   req_i  : per-master request vector
//   last_i : index granted most recently; search starts just after it
//   gnt_o  : one-hot grant (all zero when no request)
//   idx_o  : index of the granted master
module tlul_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    int   c;
    logic found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        c     = 0;
        // Walk N slots starting one past last_i so last_i itself is checked last.
        for (int k = 1; k <= N; k++) begin
            c = (int'(last_i) + k) % N;
            if (!found && req_i[c]) begin
                found    = 1'b1;
                gnt_o[c] = 1'b1;
                idx_o    = IW'(c);
            end
        end
    end

endmodule

// File: rtl/tlul_xbar_nto1.sv
// N-master to 1-slave TL-UL crossbar.
//   m_a_*  : packed per-master A channels (master i at slice i)
//   m_d_*  : packed per-master D channels
//   s_a_*  : slave A channel, source = {master index, master source}
//   s_d_*  : slave D channel, routed back on the upper source bits
// A requests are arbitrated round-robin, registered, then either forwarded
// (address inside the slave window) or answered by a single-entry internal
// error responder. D responses route combinationally.
module tlul_xbar_nto1 import tlul_pkg::*; #(
    parameter int          NUM_MASTERS  = 4,
    parameter int          ADDR_WIDTH   = 32,
    parameter int          DATA_WIDTH   = 32,
    parameter int          MASK_WIDTH   = DATA_WIDTH / 8,
    parameter int          SIZE_WIDTH   = 3,
    parameter int          SRC_WIDTH    = 1,
    parameter int          SINK_WIDTH   = 1,
    parameter int          OPCODE_WIDTH = 3,
    parameter int          PARAM_WIDTH  = 3,
    parameter int          IDX_WIDTH    = $clog2(NUM_MASTERS),
    parameter logic [31:0] SLV_BASE     = 32'h0000_0000,
    parameter logic [31:0] SLV_MASK     = 32'hF000_0000
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_MASTERS-1:0]               m_a_valid,
    output logic [NUM_MASTERS-1:0]               m_a_ready,
    input  logic [NUM_MASTERS*OPCODE_WIDTH-1:0]  m_a_opcode,
    input  logic [NUM_MASTERS*PARAM_WIDTH-1:0]   m_a_param,
    input  logic [NUM_MASTERS*SIZE_WIDTH-1:0]    m_a_size,
    input  logic [NUM_MASTERS*SRC_WIDTH-1:0]     m_a_source,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]    m_a_address,
    input  logic [NUM_MASTERS*MASK_WIDTH-1:0]    m_a_mask,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]    m_a_data,
    output logic [NUM_MASTERS-1:0]               m_d_valid,
    input  logic [NUM_MASTERS-1:0]               m_d_ready,
    output logic [NUM_MASTERS*OPCODE_WIDTH-1:0]  m_d_opcode,
    output logic [NUM_MASTERS*PARAM_WIDTH-1:0]   m_d_param,
    output logic [NUM_MASTERS*SIZE_WIDTH-1:0]    m_d_size,
    output logic [NUM_MASTERS*SRC_WIDTH-1:0]     m_d_source,
    output logic [NUM_MASTERS*SINK_WIDTH-1:0]    m_d_sink,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0]    m_d_data,
    output logic [NUM_MASTERS-1:0]               m_d_error,
    output logic                                 s_a_valid,
    input  logic                                 s_a_ready,
    output logic [OPCODE_WIDTH-1:0]              s_a_opcode,
    output logic [PARAM_WIDTH-1:0]               s_a_param,
    output logic [SIZE_WIDTH-1:0]                s_a_size,
    output logic [IDX_WIDTH+SRC_WIDTH-1:0]       s_a_source,
    output logic [ADDR_WIDTH-1:0]                s_a_address,
    output logic [MASK_WIDTH-1:0]                s_a_mask,
    output logic [DATA_WIDTH-1:0]                s_a_data,
    input  logic                                 s_d_valid,
    output logic                                 s_d_ready,
    input  logic [OPCODE_WIDTH-1:0]              s_d_opcode,
    input  logic [PARAM_WIDTH-1:0]               s_d_param,
    input  logic [SIZE_WIDTH-1:0]                s_d_size,
    input  logic [IDX_WIDTH+SRC_WIDTH-1:0]       s_d_source,
    input  logic [SINK_WIDTH-1:0]                s_d_sink,
    input  logic [DATA_WIDTH-1:0]                s_d_data,
    input  logic                                 s_d_error
);

    localparam int SW = IDX_WIDTH + SRC_WIDTH;

    a_state_e               state_q, state_d;
    logic [IDX_WIDTH-1:0]   rr_last_q, rr_last_d, grant_q, grant_d;
    logic [OPCODE_WIDTH-1:0] op_q, op_d;
    logic [PARAM_WIDTH-1:0] par_q, par_d;
    logic [SIZE_WIDTH-1:0]  size_q, size_d;
    logic [SRC_WIDTH-1:0]   src_q, src_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [MASK_WIDTH-1:0]  mask_q, mask_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   hit_q, hit_d;

    logic                   err_pending_q, err_pending_d, err_load;
    logic [IDX_WIDTH-1:0]   err_idx_q, err_idx_d;
    logic [OPCODE_WIDTH-1:0] err_op_q, err_op_d, err_rsp_op;
    logic [SIZE_WIDTH-1:0]  err_size_q, err_size_d;
    logic [SRC_WIDTH-1:0]   err_src_q, err_src_d;

    logic [NUM_MASTERS-1:0] arb_gnt;
    logic [IDX_WIDTH-1:0]   arb_idx;

    logic [OPCODE_WIDTH-1:0] sel_op;
    logic [PARAM_WIDTH-1:0] sel_par;
    logic [SIZE_WIDTH-1:0]  sel_size;
    logic [SRC_WIDTH-1:0]   sel_src;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [MASK_WIDTH-1:0]  sel_mask;
    logic [DATA_WIDTH-1:0]  sel_data;

    logic [IDX_WIDTH-1:0]   d_idx;
    logic                   d_bad;

    tlul_rr_arbiter #(.N(NUM_MASTERS), .IW(IDX_WIDTH)) u_arb (
        .req_i  (m_a_valid),
        .last_i (rr_last_q),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx)
    );

    // AND-OR mux of the granted master's A fields.
    always_comb begin
        sel_op   = '0;
        sel_par  = '0;
        sel_size = '0;
        sel_src  = '0;
        sel_addr = '0;
        sel_mask = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (arb_gnt[i]) begin
                sel_op   = m_a_opcode[i*OPCODE_WIDTH +: OPCODE_WIDTH];
                sel_par  = m_a_param[i*PARAM_WIDTH +: PARAM_WIDTH];
                sel_size = m_a_size[i*SIZE_WIDTH +: SIZE_WIDTH];
                sel_src  = m_a_source[i*SRC_WIDTH +: SRC_WIDTH];
                sel_addr = m_a_address[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_mask = m_a_mask[i*MASK_WIDTH +: MASK_WIDTH];
                sel_data = m_a_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // A-channel FSM: ARB registers a winner, FWD hands it to the slave or
    // to the error responder.
    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        grant_d   = grant_q;
        op_d      = op_q;
        par_d     = par_q;
        size_d    = size_q;
        src_d     = src_q;
        addr_d    = addr_q;
        mask_d    = mask_q;
        data_d    = data_q;
        hit_d     = hit_q;
        err_load  = 1'b0;
        m_a_ready = '0;
        s_a_valid = 1'b0;
        case (state_q)
            ARB: begin
                if (|m_a_valid) begin
                    grant_d = arb_idx;
                    op_d    = sel_op;
                    par_d   = sel_par;
                    size_d  = sel_size;
                    src_d   = sel_src;
                    addr_d  = sel_addr;
                    mask_d  = sel_mask;
                    data_d  = sel_data;
                    hit_d   = ((32'(sel_addr) & SLV_MASK) == SLV_BASE);
                    state_d = FWD;
                end
            end
            FWD: begin
                if (hit_q) begin
                    s_a_valid          = 1'b1;
                    m_a_ready[grant_q] = s_a_ready;
                    if (s_a_ready) begin
                        rr_last_d = grant_q;
                        state_d   = ARB;
                    end
                end else if (!err_pending_q) begin
                    // Miss: accept the beat and answer it internally.
                    m_a_ready[grant_q] = 1'b1;
                    err_load           = 1'b1;
                    rr_last_d          = grant_q;
                    state_d            = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    // Error responder bookkeeping; a load only happens while empty.
    always_comb begin
        err_pending_d = err_pending_q;
        err_idx_d     = err_idx_q;
        err_op_d      = err_op_q;
        err_size_d    = err_size_q;
        err_src_d     = err_src_q;
        if (err_load) begin
            err_pending_d = 1'b1;
            err_idx_d     = grant_q;
            err_op_d      = op_q;
            err_size_d    = size_q;
            err_src_d     = src_q;
        end else if (err_pending_q && m_d_ready[err_idx_q]) begin
            err_pending_d = 1'b0;
        end
    end

    assign err_rsp_op = (err_op_q == OPCODE_WIDTH'(GET)) ? OPCODE_WIDTH'(ACCESS_ACK_DATA)
                                                         : OPCODE_WIDTH'(ACCESS_ACK);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ARB;
            rr_last_q     <= IDX_WIDTH'(NUM_MASTERS - 1);
            grant_q       <= '0;
            op_q          <= '0;
            par_q         <= '0;
            size_q        <= '0;
            src_q         <= '0;
            addr_q        <= '0;
            mask_q        <= '0;
            data_q        <= '0;
            hit_q         <= 1'b0;
            err_pending_q <= 1'b0;
            err_idx_q     <= '0;
            err_op_q      <= '0;
            err_size_q    <= '0;
            err_src_q     <= '0;
        end else begin
            state_q       <= state_d;
            rr_last_q     <= rr_last_d;
            grant_q       <= grant_d;
            op_q          <= op_d;
            par_q         <= par_d;
            size_q        <= size_d;
            src_q         <= src_d;
            addr_q        <= addr_d;
            mask_q        <= mask_d;
            data_q        <= data_d;
            hit_q         <= hit_d;
            err_pending_q <= err_pending_d;
            err_idx_q     <= err_idx_d;
            err_op_q      <= err_op_d;
            err_size_q    <= err_size_d;
            err_src_q     <= err_src_d;
        end
    end

    assign s_a_opcode  = op_q;
    assign s_a_param   = par_q;
    assign s_a_size    = size_q;
    assign s_a_source  = {grant_q, src_q};
    assign s_a_address = addr_q;
    assign s_a_mask    = mask_q;
    assign s_a_data    = data_q;

    // D routing on the master-index bits of the returned source.
    assign d_idx = s_d_source[SW-1 -: IDX_WIDTH];
    assign d_bad = ({1'b0, d_idx} >= (IDX_WIDTH+1)'(NUM_MASTERS));

    // Unknown index: swallow the response. Pending error to the same
    // master has priority over the slave response.
    assign s_d_ready = d_bad ? 1'b1 :
                       (err_pending_q && (err_idx_q == d_idx)) ? 1'b0 : m_d_ready[d_idx];

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_d
        logic err_sel, sd_sel;
        assign err_sel = err_pending_q && (err_idx_q == IDX_WIDTH'(i));
        assign sd_sel  = s_d_valid && !d_bad && (d_idx == IDX_WIDTH'(i));
        assign m_d_valid[i] = err_sel || sd_sel;
        assign m_d_opcode[i*OPCODE_WIDTH +: OPCODE_WIDTH] = err_sel ? err_rsp_op : s_d_opcode;
        assign m_d_param[i*PARAM_WIDTH +: PARAM_WIDTH]    = err_sel ? '0 : s_d_param;
        assign m_d_size[i*SIZE_WIDTH +: SIZE_WIDTH]       = err_sel ? err_size_q : s_d_size;
        assign m_d_source[i*SRC_WIDTH +: SRC_WIDTH]       = err_sel ? err_src_q : s_d_source[SRC_WIDTH-1:0];
        assign m_d_sink[i*SINK_WIDTH +: SINK_WIDTH]       = err_sel ? '0 : s_d_sink;
        assign m_d_data[i*DATA_WIDTH +: DATA_WIDTH]       = err_sel ? '0 : s_d_data;
        assign m_d_error[i] = err_sel ? 1'b1 : s_d_error;
    end

endmodule

// File: tb/tb_tlul_xbar_nto1.sv
module tb_tlul_xbar_nto1;
    localparam int N = 4;

    logic clk = 1'b0, reset = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    m_a_valid, m_a_ready, m_a_source, m_d_valid, m_d_ready, m_d_source, m_d_sink, m_d_error;
    logic [N*3-1:0]  m_a_opcode, m_a_param, m_a_size, m_d_opcode, m_d_param, m_d_size;
    logic [N*32-1:0] m_a_address, m_a_data, m_d_data;
    logic [N*4-1:0]  m_a_mask;
    logic            s_a_valid, s_a_ready, s_d_valid, s_d_ready, s_d_sink, s_d_error;
    logic [2:0]      s_a_opcode, s_a_param, s_a_size, s_a_source;
    logic [2:0]      s_d_opcode, s_d_param, s_d_size, s_d_source;
    logic [31:0]     s_a_address, s_a_data, s_d_data;
    logic [3:0]      s_a_mask;

    tlul_xbar_nto1 #(.NUM_MASTERS(N)) dut (
        .clk(clk), .reset(reset),
        .m_a_valid(m_a_valid), .m_a_ready(m_a_ready), .m_a_opcode(m_a_opcode), .m_a_param(m_a_param),
        .m_a_size(m_a_size), .m_a_source(m_a_source), .m_a_address(m_a_address), .m_a_mask(m_a_mask),
        .m_a_data(m_a_data), .m_d_valid(m_d_valid), .m_d_ready(m_d_ready), .m_d_opcode(m_d_opcode),
        .m_d_param(m_d_param), .m_d_size(m_d_size), .m_d_source(m_d_source), .m_d_sink(m_d_sink),
        .m_d_data(m_d_data), .m_d_error(m_d_error), .s_a_valid(s_a_valid), .s_a_ready(s_a_ready),
        .s_a_opcode(s_a_opcode), .s_a_param(s_a_param), .s_a_size(s_a_size), .s_a_source(s_a_source),
        .s_a_address(s_a_address), .s_a_mask(s_a_mask), .s_a_data(s_a_data), .s_d_valid(s_d_valid),
        .s_d_ready(s_d_ready), .s_d_opcode(s_d_opcode), .s_d_param(s_d_param), .s_d_size(s_d_size),
        .s_d_source(s_d_source), .s_d_sink(s_d_sink), .s_d_data(s_d_data), .s_d_error(s_d_error)
    );

    // Three-master instance: index 3 is out of range, exercising the drop path.
    logic [2:0]  b_m_a_valid, b_m_a_ready, b_m_a_source, b_m_d_valid, b_m_d_ready, b_m_d_source, b_m_d_sink, b_m_d_error;
    logic [8:0]  b_m_a_opcode, b_m_a_param, b_m_a_size, b_m_d_opcode, b_m_d_param, b_m_d_size;
    logic [95:0] b_m_a_address, b_m_a_data, b_m_d_data;
    logic [11:0] b_m_a_mask;
    logic        b_s_a_valid, b_s_a_ready, b_s_d_valid, b_s_d_ready, b_s_d_sink, b_s_d_error;
    logic [2:0]  b_s_a_opcode, b_s_a_param, b_s_a_size, b_s_a_source, b_s_d_opcode, b_s_d_param, b_s_d_size, b_s_d_source;
    logic [31:0] b_s_a_address, b_s_a_data, b_s_d_data;
    logic [3:0]  b_s_a_mask;

    tlul_xbar_nto1 #(.NUM_MASTERS(3)) dut_b (
        .clk(clk), .reset(reset),
        .m_a_valid(b_m_a_valid), .m_a_ready(b_m_a_ready), .m_a_opcode(b_m_a_opcode), .m_a_param(b_m_a_param),
        .m_a_size(b_m_a_size), .m_a_source(b_m_a_source), .m_a_address(b_m_a_address), .m_a_mask(b_m_a_mask),
        .m_a_data(b_m_a_data), .m_d_valid(b_m_d_valid), .m_d_ready(b_m_d_ready), .m_d_opcode(b_m_d_opcode),
        .m_d_param(b_m_d_param), .m_d_size(b_m_d_size), .m_d_source(b_m_d_source), .m_d_sink(b_m_d_sink),
        .m_d_data(b_m_d_data), .m_d_error(b_m_d_error), .s_a_valid(b_s_a_valid), .s_a_ready(b_s_a_ready),
        .s_a_opcode(b_s_a_opcode), .s_a_param(b_s_a_param), .s_a_size(b_s_a_size), .s_a_source(b_s_a_source),
        .s_a_address(b_s_a_address), .s_a_mask(b_s_a_mask), .s_a_data(b_s_a_data), .s_d_valid(b_s_d_valid),
        .s_d_ready(b_s_d_ready), .s_d_opcode(b_s_d_opcode), .s_d_param(b_s_d_param), .s_d_size(b_s_d_size),
        .s_d_source(b_s_d_source), .s_d_sink(b_s_d_sink), .s_d_data(b_s_d_data), .s_d_error(b_s_d_error)
    );

    int nvec = 0, nmis = 0, cyc = 0;
    int hs_m[$], hs_c[$];
    logic [N-1:0] hs_a;
    logic         hs_sd;

    // Behavioural model: one outstanding granted beat, one error entry.
    bit          model_ok = 0, busy = 0, c_hit = 0, ev = 0;
    int          cm = 0, last = N-1, em = 0;
    logic [2:0]  c_op, c_par, c_sz, eop, esz;
    logic        c_src, esrc;
    logic [31:0] c_addr, c_data;
    logic [3:0]  c_mask;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic compare_model();
        logic [N-1:0] er, ev_v;
        int sdi;
        if (!model_ok) return;
        chk("s_a_valid", s_a_valid, busy && c_hit);
        if (busy && c_hit) begin
            chk("s_a_opcode", s_a_opcode, c_op);
            chk("s_a_param", s_a_param, c_par);
            chk("s_a_size", s_a_size, c_sz);
            chk("s_a_source", s_a_source, cm * 2 + int'(c_src));
            chk("s_a_address", s_a_address, c_addr);
            chk("s_a_mask", s_a_mask, c_mask);
            chk("s_a_data", s_a_data, c_data);
        end
        er = '0;
        if (busy) er[cm] = c_hit ? s_a_ready : !ev;
        chk("m_a_ready", m_a_ready, er);
        sdi = int'(s_d_source) / 2;
        ev_v = '0;
        for (int i = 0; i < N; i++) ev_v[i] = (ev && em == i) || (s_d_valid && sdi == i);
        chk("m_d_valid", m_d_valid, ev_v);
        for (int i = 0; i < N; i++) begin
            if (ev && em == i) begin
                chk("err_opcode", m_d_opcode[i*3 +: 3], (eop == 3'd4) ? 1 : 0);
                chk("err_size", m_d_size[i*3 +: 3], esz);
                chk("err_source", m_d_source[i], esrc);
                chk("err_zero", {m_d_param[i*3 +: 3], m_d_sink[i], m_d_data[i*32 +: 32]}, 0);
                chk("err_flag", m_d_error[i], 1);
            end else if (ev_v[i]) begin
                chk("d_fields", {m_d_opcode[i*3 +: 3], m_d_param[i*3 +: 3], m_d_size[i*3 +: 3], m_d_source[i],
                                 m_d_sink[i], m_d_data[i*32 +: 32], m_d_error[i]},
                                {s_d_opcode, s_d_param, s_d_size, s_d_source[0], s_d_sink, s_d_data, s_d_error});
            end
        end
        if (s_d_valid) chk("s_d_ready", s_d_ready, (ev && em == sdi) ? 1'b0 : m_d_ready[sdi]);
    endtask

    task automatic model_step();
        bit old_ev;
        int c;
        if (reset) begin busy = 0; ev = 0; last = N-1; model_ok = 1; return; end
        if (!model_ok) return;
        old_ev = ev;
        if (ev && m_d_ready[em]) ev = 0;
        if (!busy) begin
            for (int k = 1; k <= N; k++) begin
                c = (last + k) % N;
                if (m_a_valid[c]) begin
                    busy = 1; cm = c;
                    c_op = m_a_opcode[c*3 +: 3]; c_par = m_a_param[c*3 +: 3]; c_sz = m_a_size[c*3 +: 3];
                    c_src = m_a_source[c]; c_addr = m_a_address[c*32 +: 32];
                    c_mask = m_a_mask[c*4 +: 4]; c_data = m_a_data[c*32 +: 32];
                    c_hit = ((c_addr & 32'hF000_0000) == 32'h0);
                    break;
                end
            end
        end else if (c_hit) begin
            if (s_a_ready) begin last = cm; busy = 0; end
        end else if (!old_ev) begin
            ev = 1; em = cm; eop = c_op; esz = c_sz; esrc = c_src; last = cm; busy = 0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        compare_model();
        hs_a  = m_a_valid & m_a_ready;
        hs_sd = s_d_valid & s_d_ready;
        for (int i = 0; i < N; i++) if (hs_a[i]) begin hs_m.push_back(i); hs_c.push_back(cyc); end
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic [31:0] addr, input logic src,
                           input logic [2:0] sz, input logic [31:0] data);
        m_a_valid[i] = 1'b1;
        m_a_opcode[i*3 +: 3] = op;
        m_a_param[i*3 +: 3] = 3'($urandom_range(0, 7));
        m_a_size[i*3 +: 3] = sz;
        m_a_source[i] = src;
        m_a_address[i*32 +: 32] = addr;
        m_a_mask[i*4 +: 4] = 4'($urandom_range(0, 15));
        m_a_data[i*32 +: 32] = data;
    endtask

    task automatic do_reset();
        reset = 1'b1; m_a_valid = '0; s_d_valid = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic drive_random();
        logic [2:0] ops [3] = '{3'd0, 3'd1, 3'd4};
        logic [31:0] a;
        for (int i = 0; i < N; i++) begin
            if (hs_a[i] || !m_a_valid[i]) begin
                if ($urandom_range(0, 2) != 0) begin
                    a = {4'h0, 28'($urandom)};
                    if ($urandom_range(0, 4) == 0) a[31:28] = 4'($urandom_range(1, 15));
                    set_req(i, ops[$urandom_range(0, 2)], a, 1'($urandom), 3'($urandom), $urandom);
                end else m_a_valid[i] = 1'b0;
            end
        end
        if (hs_sd || !s_d_valid) begin
            s_d_valid = 1'($urandom); s_d_opcode = 3'($urandom); s_d_param = 3'($urandom);
            s_d_size = 3'($urandom); s_d_source = 3'($urandom); s_d_sink = 1'($urandom);
            s_d_data = $urandom; s_d_error = 1'($urandom);
        end
        s_a_ready = ($urandom_range(0, 3) != 0);
        m_d_ready = 4'($urandom);
        reset = ($urandom_range(0, 499) == 0);
    endtask

    initial begin
        int exp_order [5] = '{0, 1, 2, 3, 0};
        m_a_valid = '0; m_a_opcode = '0; m_a_param = '0; m_a_size = '0; m_a_source = '0;
        m_a_address = '0; m_a_mask = '0; m_a_data = '0; m_d_ready = '0; s_a_ready = 1'b0;
        s_d_valid = 1'b0; s_d_opcode = '0; s_d_param = '0; s_d_size = '0; s_d_source = '0;
        s_d_sink = 1'b0; s_d_data = '0; s_d_error = 1'b0;
        b_m_a_valid = '0; b_m_a_opcode = '0; b_m_a_param = '0; b_m_a_size = '0; b_m_a_source = '0;
        b_m_a_address = '0; b_m_a_mask = '0; b_m_a_data = '0; b_m_d_ready = '0; b_s_a_ready = 1'b0;
        b_s_d_valid = 1'b0; b_s_d_opcode = '0; b_s_d_param = '0; b_s_d_size = '0; b_s_d_source = '0;
        b_s_d_sink = 1'b0; b_s_d_data = '0; b_s_d_error = 1'b0;

        // Reset state
        step(); step(); reset = 1'b0;
        chk("rst_s_a_valid", s_a_valid, 0);
        chk("rst_m_a_ready", m_a_ready, 0);
        chk("rst_m_d_valid", m_d_valid, 0);

        // All masters valid: grants 0,1,2,3,0, one every 2 cycles
        s_a_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 3'd4, 32'h100 * i, 1'b0, 3'd2, 32'h0);
        hs_m.delete(); hs_c.delete();
        repeat (10) step();
        chk("rr_count", hs_m.size(), 5);
        for (int k = 0; k < 5 && k < hs_m.size(); k++) begin
            chk("rr_order", hs_m[k], exp_order[k]);
            if (k > 0) chk("rr_spacing", hs_c[k] - hs_c[k-1], 2);
        end
        do_reset();

        // Master 2 Get, one-cycle latency, ready follows s_a_ready
        s_a_ready = 1'b0;
        set_req(2, 3'd4, 32'h0000_1000, 1'b1, 3'd2, 32'h0);
        step();
        chk("t1_s_a_valid", s_a_valid, 1);
        chk("t1_s_a_source", s_a_source, 3'b101);
        chk("t1_s_a_opcode", s_a_opcode, 4);
        chk("t1_s_a_address", s_a_address, 32'h0000_1000);
        chk("t1_m_a_ready_lo", m_a_ready, 0);
        s_a_ready = 1'b1; #1;
        chk("t1_m_a_ready", m_a_ready, 4'b0100);
        hs_m.delete(); hs_c.delete();
        step(); m_a_valid[2] = 1'b0;
        chk("t1_hs", hs_m.size(), 1);

        // Master 1 stalled by slave for 5 cycles
        s_a_ready = 1'b0;
        set_req(1, 3'd0, 32'h0ABC_0040, 1'b0, 3'd2, 32'h1234_5678);
        step();
        hs_m.delete(); hs_c.delete();
        repeat (5) begin
            chk("t3_addr", s_a_address, 32'h0ABC_0040);
            chk("t3_data", s_a_data, 32'h1234_5678);
            chk("t3_src", s_a_source, 3'b010);
            chk("t3_ready", m_a_ready, 0);
            step();
        end
        s_a_ready = 1'b1;
        step(); m_a_valid[1] = 1'b0;
        chk("t3_hs_cnt", hs_m.size(), 1);
        if (hs_m.size() > 0) chk("t3_hs_m", hs_m[0], 1);

        // Window miss: internal error response, second miss stalls
        m_d_ready = '0;
        set_req(0, 3'd4, 32'h8000_0000, 1'b1, 3'd2, 32'h0);
        step();
        chk("t4_s_a_valid", s_a_valid, 0);
        chk("t4_m_a_ready", m_a_ready, 4'b0001);
        step();
        set_req(0, 3'd0, 32'h9000_0000, 1'b0, 3'd1, 32'h5555_AAAA);
        chk("t4_d_valid", m_d_valid, 4'b0001);
        chk("t4_d_opcode", m_d_opcode[2:0], 1);
        chk("t4_d_error", m_d_error[0], 1);
        chk("t4_d_data", m_d_data[31:0], 0);
        chk("t4_d_source", m_d_source[0], 1);
        chk("t4_d_size", m_d_size[2:0], 2);
        repeat (3) begin
            step();
            chk("t4_stall_ready", m_a_ready, 0);
            chk("t4_stall_dv", m_d_valid, 4'b0001);
        end
        m_d_ready = 4'b0001;
        step();
        chk("t4_second_ready", m_a_ready, 4'b0001);
        chk("t4_cleared", m_d_valid, 0);
        step(); m_a_valid[0] = 1'b0;
        chk("t4_second_dv", m_d_valid, 4'b0001);
        chk("t4_second_op", m_d_opcode[2:0], 0);
        step();
        chk("t4_done", m_d_valid, 0);
        m_d_ready = '0;

        // D routing by source, backpressure
        s_d_valid = 1'b1; s_d_source = 3'b110; s_d_opcode = 3'd1; s_d_data = 32'hCAFE_F00D;
        s_d_size = 3'd2; s_d_error = 1'b0; #1;
        chk("t5_dv", m_d_valid, 4'b1000);
        chk("t5_src", m_d_source[3], 0);
        chk("t5_data", m_d_data[127:96], 32'hCAFE_F00D);
        chk("t5_sready_lo", s_d_ready, 0);
        m_d_ready = 4'b1000; #1;
        chk("t5_sready_hi", s_d_ready, 1);
        step(); s_d_valid = 1'b0; m_d_ready = '0;

        // Out-of-range index on a 3-master crossbar is dropped
        b_s_d_valid = 1'b1; b_s_d_source = 3'b110; #1;
        chk("bad_sready", b_s_d_ready, 1);
        chk("bad_dv", b_m_d_valid, 0);
        b_s_d_source = 3'b100; #1;
        chk("b_route_dv", b_m_d_valid, 3'b100);
        chk("b_route_sready", b_s_d_ready, 0);
        b_s_d_valid = 1'b0;

        // Reset during FWD with an error pending
        do_reset();
        set_req(0, 3'd4, 32'hF000_0000, 1'b0, 3'd0, 32'h0);
        step(); step(); m_a_valid[0] = 1'b0;
        chk("t6_err_pend", m_d_valid, 4'b0001);
        s_a_ready = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 3'd1, 32'h20 * i, 1'b1, 3'd2, $urandom);
        step();
        chk("t6_fwd", s_a_valid, 1);
        reset = 1'b1; step(); reset = 1'b0;
        chk("t6_s_a_valid", s_a_valid, 0);
        chk("t6_m_a_ready", m_a_ready, 0);
        chk("t6_m_d_valid", m_d_valid, 0);
        s_a_ready = 1'b1;
        hs_m.delete(); hs_c.delete();
        repeat (3) step();
        chk("t6_hs_cnt", hs_m.size() > 0, 1);
        if (hs_m.size() > 0) chk("t6_first", hs_m[0], 0);
        do_reset();

        // Randomized traffic against the model
        repeat (4000) begin
            drive_random();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
